rv_decode_exec: RTL and testbench
=================================

# rv_decode_exec

Single-cycle decode/execute datapath slice for the multi-cycle RV32I controller. It holds the current instruction, decodes it into control fields, and executes it on the ALU. It also computes the next PC, including branch resolution. The controller supplies the PC and the register-file operands it has latched, and sequences IF/ID/EXE/MEM/WB from the presence flags produced here.

## Interface
No parameters.
- iwClk  in  1  clock, rising edge
- iwnRst  in  1  reset, asynchronous, active-low
- iwLoadInstr  in  1  capture iwInstr on the next rising edge
- iwInstr  in  32  fetched instruction word
- iwPc  in  32  PC of the current instruction
- iwRs1Value, iwRs2Value  in  32 each  latched rs1/rs2 operands
- owReadReg1, owReadReg2, owWriteReg  out  5 each  rs1, rs2, rd fields
- owWriteRegSource  out  2  0 ALU, 1 memory, 2 immediate
- owWriteRegImmediate  out  32  rd value for LUI/AUIPC/JAL/JALR
- owDMemWrite  out  1  store
- owDMemSignExtend  out  1  signed load
- owDMemAccess  out  2  0 byte, 1 half, 2 word
- owMemPresent, owWbPresent  out  1 each  MEM / WB stage needed
- ownIllegal  out  1  low means unsupported instruction
- owAluResult  out  32  ALU result
- owAluZero, owAluSign  out  1 each  result==0; result[31]
- owBranchTaken  out  1  ~owAluZero XOR branch-inverted
- owNextPc  out  32  next PC

## Operation
- Instruction register:
  - Resets to 0x00000013 (NOP).
  - Loads iwInstr when iwLoadInstr is high.
- ALU ops (4-bit): ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9; others yield 0.
  - Arithmetic wraps modulo 2^32.
  - Shift amount is B[4:0].
  - SLT/SLTU return 0 or 1.
- ALU operands:
  - A = iwRs1Value.
  - B = iwRs2Value for R-type and branches.
  - B = sign-extended immediate otherwise (I-type; S-type for stores).
- Decode (RV32I):
  - OP and OP-IMM map funct3/funct7 to the ALU op. SRAI and SUB use funct7[5].
  - LOAD and STORE use ADD; access size and sign come from funct3.
  - LUI: immediate = imm<<12.
  - AUIPC: immediate = iwPc + (imm<<12).
  - JAL and JALR: immediate = iwPc+4, source 2.
  - owMemPresent = 1 for loads and stores only.
  - owWbPresent = 1 for every rd-writing instruction, including when rd = 0.
- Branches:
  - BEQ/BNE use SUB; BLT/BGE use SLT; BLTU/BGEU use SLTU.
  - Branch-inverted = 1 for BEQ, BGE, BGEU.
- Next PC (internal 2-bit select):
  - sequential: iwPc+4
  - JAL: iwPc + sext(imm20<<1)
  - JALR: (iwRs1Value + sext(imm12)) & ~1
  - branch: owBranchTaken ? iwPc + sext(imm12<<1) : iwPc+4
- FENCE decodes as a NOP.
- ownIllegal = 0 for SYSTEM, unknown opcodes, and invalid funct3/funct7 combinations. An illegal instruction has no writes and no presence flags.
- While iwnRst is low, all outputs decode a NOP:
  - ownIllegal = 1
  - owDMemWrite = 0
  - owMemPresent = 0
  - owWbPresent = 1, rd = 0

## Timing
- The instruction register is the only state. It is asynchronously cleared to NOP on reset and updates at the iwClk rising edge.
- All outputs are combinational from the instruction register and the inputs. Latency is zero cycles after capture.
- Reset asserted mid-operation forces NOP immediately.
- If iwLoadInstr is high at the edge where reset releases, the instruction loads at that edge.

## Structure
- Shared package holds:
  - opcode constants
  - ALU op codes
  - write-source, memory-access and next-PC-select encodings
  - the NOP constant
- The natural sub-module is alu (A, B, op → result, zero, sign).
- Decode and next-PC logic stay in the top level.

## Test plan
- Reset, then release with no load → instruction is 0x00000013; ownIllegal=1, owWbPresent=1, owWriteReg=0, owNextPc=iwPc+4.
- Load 0x00208133 (add x2,x1,x2) with rs1=5, rs2=0xFFFFFFFF → owAluResult=4, source 0, owWriteReg=2.
- BEQ with offset +16, rs1=rs2=7, iwPc=0x100 → owAluZero=1, owBranchTaken=1, owNextPc=0x110. With rs2=8 → owNextPc=0x104.
- JALR x1,12(x5) with rs1=0x203, iwPc=0x40 → owNextPc=0x20E, owWriteRegImmediate=0x44.
- LH with imm −4, rs1=0x1000 → owAluResult=0xFFC, owMemPresent=1, owDMemAccess=1, owDMemSignExtend=1.
- ECALL 0x00000073 → ownIllegal=0. SRAI by 4 of 0x80000000 → 0xF8000000.

Source files
------------

// File: rtl/rv_decode_exec_pkg.sv
// Shared encodings for the RV32I decode/execute slice: opcodes, ALU ops,
// write-back source, memory access size and next-PC select.
package rv_decode_exec_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    WSRC_ALU = 2'd0,
    WSRC_MEM = 2'd1,
    WSRC_IMM = 2'd2
  } wsrc_e;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_access_e;

  typedef enum logic [1:0] {
    NPC_SEQ    = 2'd0,
    NPC_JAL    = 2'd1,
    NPC_JALR   = 2'd2,
    NPC_BRANCH = 2'd3
  } npc_sel_e;

  // alt selects SUB/SRA; callers only assert it where funct7[5] is meaningful
  function automatic alu_op_e alu_op_decode(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'd0:    alu_op_decode = alt ? ALU_SUB : ALU_ADD;
      3'd1:    alu_op_decode = ALU_SLL;
      3'd2:    alu_op_decode = ALU_SLT;
      3'd3:    alu_op_decode = ALU_SLTU;
      3'd4:    alu_op_decode = ALU_XOR;
      3'd5:    alu_op_decode = alt ? ALU_SRA : ALU_SRL;
      3'd6:    alu_op_decode = ALU_OR;
      default: alu_op_decode = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv_decode_exec_if.sv
// Controller-facing bundle of the decode/execute slice: instruction and
// operand inputs, decoded control fields and execution results.
interface rv_decode_exec_if;
  logic        iwLoadInstr;
  logic [31:0] iwInstr;
  logic [31:0] iwPc;
  logic [31:0] iwRs1Value;
  logic [31:0] iwRs2Value;
  logic [4:0]  owReadReg1;
  logic [4:0]  owReadReg2;
  logic [4:0]  owWriteReg;
  logic [1:0]  owWriteRegSource;
  logic [31:0] owWriteRegImmediate;
  logic        owDMemWrite;
  logic        owDMemSignExtend;
  logic [1:0]  owDMemAccess;
  logic        owMemPresent;
  logic        owWbPresent;
  logic        ownIllegal;
  logic [31:0] owAluResult;
  logic        owAluZero;
  logic        owAluSign;
  logic        owBranchTaken;
  logic [31:0] owNextPc;

  modport slave (
    input  iwLoadInstr, iwInstr, iwPc, iwRs1Value, iwRs2Value,
    output owReadReg1, owReadReg2, owWriteReg, owWriteRegSource, owWriteRegImmediate,
           owDMemWrite, owDMemSignExtend, owDMemAccess, owMemPresent, owWbPresent,
           ownIllegal, owAluResult, owAluZero, owAluSign, owBranchTaken, owNextPc
  );

  modport master (
    output iwLoadInstr, iwInstr, iwPc, iwRs1Value, iwRs2Value,
    input  owReadReg1, owReadReg2, owWriteReg, owWriteRegSource, owWriteRegImmediate,
           owDMemWrite, owDMemSignExtend, owDMemAccess, owMemPresent, owWbPresent,
           ownIllegal, owAluResult, owAluZero, owAluSign, owBranchTaken, owNextPc
  );
endinterface

// File: rtl/rv_decode_exec_alu.sv
// Combinational RV32I ALU; unlisted op codes produce zero.
module rv_decode_exec_alu
  import rv_decode_exec_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_op_e     op_i,
  output logic [31:0] result_o,
  output logic        zero_o,
  output logic        sign_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:  result_o = a_i + b_i;
      ALU_SUB:  result_o = a_i - b_i;
      ALU_SLL:  result_o = a_i << b_i[4:0];
      ALU_SLT:  result_o = {31'd0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: result_o = {31'd0, a_i < b_i};
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SRL:  result_o = a_i >> b_i[4:0];
      ALU_SRA:  result_o = $unsigned($signed(a_i) >>> b_i[4:0]);
      ALU_OR:   result_o = a_i | b_i;
      ALU_AND:  result_o = a_i & b_i;
      default:  result_o = '0;
    endcase
  end

  assign zero_o = (result_o == 32'd0);
  assign sign_o = result_o[31];

endmodule

// File: rtl/rv_decode_exec.sv
// RV32I decode/execute slice: instruction register, decoder, ALU and next-PC
// resolution. Everything except the instruction register is combinational.
module rv_decode_exec
  import rv_decode_exec_pkg::*;
(
  input logic           iwClk,
  input logic           iwnRst,
  rv_decode_exec_if.slave bus
);

  logic [31:0] instr_q, instr_d;

  assign instr_d = bus.iwLoadInstr ? bus.iwInstr : instr_q;

  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) instr_q <= NOP_INSTR;
    else         instr_q <= instr_d;
  end

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;

  assign opcode = instr_q[6:0];
  assign funct3 = instr_q[14:12];
  assign funct7 = instr_q[31:25];
  assign imm_i  = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s  = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b  = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_j  = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
  assign imm_u  = {instr_q[31:12], 12'd0};

  alu_op_e     alu_op;
  wsrc_e       wsrc;
  mem_access_e mem_acc;
  npc_sel_e    npc_sel;
  logic        legal, b_use_rs2, b_use_s, is_store, load_sext, mem_pres, wb_pres, br_inv;
  logic [31:0] wimm, pc_plus4;

  assign pc_plus4 = bus.iwPc + 32'd4;

  always_comb begin
    alu_op    = ALU_ADD;
    wsrc      = WSRC_ALU;
    mem_acc   = MEM_BYTE;
    npc_sel   = NPC_SEQ;
    legal     = 1'b0;
    b_use_rs2 = 1'b0;
    b_use_s   = 1'b0;
    is_store  = 1'b0;
    load_sext = 1'b0;
    mem_pres  = 1'b0;
    wb_pres   = 1'b0;
    br_inv    = 1'b0;
    wimm      = '0;
    case (opcode)
      OPC_OP: begin
        legal     = (funct7 == 7'h00) ||
                    (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5));
        b_use_rs2 = 1'b1;
        wb_pres   = 1'b1;
        alu_op    = alu_op_decode(funct3, funct7[5]);
      end
      OPC_OP_IMM: begin
        // only the shift-immediates carry funct7; ADDI's upper imm must not select SUB
        if (funct3 == 3'd1)      legal = (funct7 == 7'h00);
        else if (funct3 == 3'd5) legal = (funct7 == 7'h00) || (funct7 == 7'h20);
        else                     legal = 1'b1;
        wb_pres = 1'b1;
        alu_op  = alu_op_decode(funct3, (funct3 == 3'd5) && funct7[5]);
      end
      OPC_LOAD: begin
        legal     = (funct3 != 3'd3) && (funct3 < 3'd6);
        mem_pres  = 1'b1;
        wb_pres   = 1'b1;
        wsrc      = WSRC_MEM;
        mem_acc   = mem_access_e'(funct3[1:0]);
        load_sext = ~funct3[2];
      end
      OPC_STORE: begin
        legal    = (funct3 < 3'd3);
        mem_pres = 1'b1;
        is_store = 1'b1;
        b_use_s  = 1'b1;
        mem_acc  = mem_access_e'(funct3[1:0]);
      end
      OPC_BRANCH: begin
        legal     = (funct3 != 3'd2) && (funct3 != 3'd3);
        b_use_rs2 = 1'b1;
        alu_op    = funct3[2] ? (funct3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
        // BEQ, BGE, BGEU take the branch when the compare result is zero
        br_inv    = funct3[2] ? funct3[0] : ~funct3[0];
        npc_sel   = NPC_BRANCH;
      end
      OPC_JAL: begin
        legal   = 1'b1;
        wb_pres = 1'b1;
        wsrc    = WSRC_IMM;
        wimm    = pc_plus4;
        npc_sel = NPC_JAL;
      end
      OPC_JALR: begin
        legal   = (funct3 == 3'd0);
        wb_pres = 1'b1;
        wsrc    = WSRC_IMM;
        wimm    = pc_plus4;
        npc_sel = NPC_JALR;
      end
      OPC_LUI: begin
        legal   = 1'b1;
        wb_pres = 1'b1;
        wsrc    = WSRC_IMM;
        wimm    = imm_u;
      end
      OPC_AUIPC: begin
        legal   = 1'b1;
        wb_pres = 1'b1;
        wsrc    = WSRC_IMM;
        wimm    = bus.iwPc + imm_u;
      end
      OPC_FENCE: begin
        legal   = (funct3 == 3'd0);
        wb_pres = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  logic [31:0] alu_b, alu_result;
  logic        alu_zero, alu_sign, br_taken;

  assign alu_b = b_use_rs2 ? bus.iwRs2Value : (b_use_s ? imm_s : imm_i);

  rv_decode_exec_alu u_alu (
    .a_i      (bus.iwRs1Value),
    .b_i      (alu_b),
    .op_i     (alu_op),
    .result_o (alu_result),
    .zero_o   (alu_zero),
    .sign_o   (alu_sign)
  );

  assign br_taken = ~alu_zero ^ br_inv;

  // JALR reuses the ALU sum rs1 + imm_i
  always_comb begin
    bus.owNextPc = pc_plus4;
    if (legal) begin
      case (npc_sel)
        NPC_JAL:    bus.owNextPc = bus.iwPc + imm_j;
        NPC_JALR:   bus.owNextPc = {alu_result[31:1], 1'b0};
        NPC_BRANCH: bus.owNextPc = br_taken ? bus.iwPc + imm_b : pc_plus4;
        default:    bus.owNextPc = pc_plus4;
      endcase
    end
  end

  assign bus.owReadReg1          = instr_q[19:15];
  assign bus.owReadReg2          = instr_q[24:20];
  assign bus.owWriteReg          = instr_q[11:7];
  assign bus.owWriteRegSource    = wsrc;
  assign bus.owWriteRegImmediate = wimm;
  assign bus.owDMemWrite         = is_store & legal;
  assign bus.owDMemSignExtend    = load_sext;
  assign bus.owDMemAccess        = mem_acc;
  assign bus.owMemPresent        = mem_pres & legal;
  assign bus.owWbPresent         = wb_pres & legal;
  assign bus.ownIllegal          = legal;
  assign bus.owAluResult         = alu_result;
  assign bus.owAluZero           = alu_zero;
  assign bus.owAluSign           = alu_sign;
  assign bus.owBranchTaken       = br_taken;

endmodule

// File: tb/tb_rv_decode_exec.sv
// Directed bench for rv_decode_exec: expectations are queued when each
// instruction is driven and compared once the DUT output settles.
module tb_rv_decode_exec;

  logic clk;
  logic rst_n;

  rv_decode_exec_if bus ();

  rv_decode_exec dut (
    .iwClk  (clk),
    .iwnRst (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int C_ALU = 1, C_BR = 2, C_NPC = 4, C_IMM = 8, C_REG = 16, C_MEM = 32;

  typedef struct {
    string       tag;
    int          care;
    logic [31:0] alu;
    logic        br;
    logic [31:0] npc;
    logic [31:0] wimm;
    logic [4:0]  rd;
    logic [1:0]  src;
    logic        nill;
    logic        mem;
    logic        wb;
    logic        dwr;
    logic        sext;
    logic [1:0]  acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int care, input logic [31:0] alu,
                          input logic br, input logic [31:0] npc, input logic [31:0] wimm,
                          input logic [4:0] rd, input logic [1:0] src, input logic nill,
                          input logic mem, input logic wb, input logic dwr,
                          input logic sext, input logic [1:0] acc);
    exp_t e;
    e.tag = tag; e.care = care; e.alu = alu; e.br = br; e.npc = npc; e.wimm = wimm;
    e.rd = rd; e.src = src; e.nill = nill; e.mem = mem; e.wb = wb; e.dwr = dwr;
    e.sext = sext; e.acc = acc;
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk({e.tag, ".nill"}, 32'(bus.ownIllegal), 32'(e.nill));
    chk({e.tag, ".mem"},  32'(bus.owMemPresent), 32'(e.mem));
    chk({e.tag, ".wb"},   32'(bus.owWbPresent), 32'(e.wb));
    chk({e.tag, ".dwr"},  32'(bus.owDMemWrite), 32'(e.dwr));
    if ((e.care & C_ALU) != 0) begin
      chk({e.tag, ".alu"},  bus.owAluResult, e.alu);
      chk({e.tag, ".zero"}, 32'(bus.owAluZero), 32'(e.alu == 32'd0));
      chk({e.tag, ".sign"}, 32'(bus.owAluSign), 32'(e.alu[31]));
    end
    if ((e.care & C_BR) != 0)  chk({e.tag, ".taken"}, 32'(bus.owBranchTaken), 32'(e.br));
    if ((e.care & C_NPC) != 0) chk({e.tag, ".npc"}, bus.owNextPc, e.npc);
    if ((e.care & C_IMM) != 0) chk({e.tag, ".wimm"}, bus.owWriteRegImmediate, e.wimm);
    if ((e.care & C_REG) != 0) begin
      chk({e.tag, ".rd"},  32'(bus.owWriteReg), 32'(e.rd));
      chk({e.tag, ".src"}, 32'(bus.owWriteRegSource), 32'(e.src));
    end
    if ((e.care & C_MEM) != 0) begin
      chk({e.tag, ".acc"},  32'(bus.owDMemAccess), 32'(e.acc));
      chk({e.tag, ".sext"}, 32'(bus.owDMemSignExtend), 32'(e.sext));
    end
    $display("[TB] txn %-10s pc=%08h alu=%08h npc=%08h nill=%0b wb=%0b mem=%0b",
             e.tag, bus.iwPc, bus.owAluResult, bus.owNextPc, bus.ownIllegal,
             bus.owWbPresent, bus.owMemPresent);
  endtask

  task automatic drive(input logic load, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    bus.iwLoadInstr = load;
    bus.iwInstr     = instr;
    bus.iwPc        = pc;
    bus.iwRs1Value  = rs1;
    bus.iwRs2Value  = rs2;
  endtask

  // One instruction: drive at negedge, capture at posedge, compare 1ns later
  task automatic step(input string tag, input logic load, input logic [31:0] instr,
                      input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                      input int care, input logic [31:0] alu, input logic br,
                      input logic [31:0] npc, input logic [31:0] wimm, input logic [4:0] rd,
                      input logic [1:0] src, input logic nill, input logic mem,
                      input logic wb, input logic dwr, input logic sext, input logic [1:0] acc);
    @(negedge clk);
    drive(load, instr, pc, rs1, rs2);
    push_exp(tag, care, alu, br, npc, wimm, rd, src, nill, mem, wb, dwr, sext, acc);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h200, 32'h0, 32'h3);
    repeat (2) @(posedge clk);
    #1;
    push_exp("rst_hold", C_NPC | C_REG, 0, 0, 32'h204, 0, 5'd0, 2'd0, 1, 0, 1, 0, 0, 0);
    check_out();

    @(negedge clk);
    rst_n = 1'b1;
    //   tag          ld instr          pc          rs1           rs2           care                         alu           br npc        wimm          rd src nI m wb dw sx acc
    step("nop_idle",  0, 32'h0,         32'h200,    32'h0,        32'h3,        C_ALU|C_NPC|C_REG,           32'h0,        0, 32'h204,   0,            0, 0, 1, 0, 1, 0, 0, 0);
    step("add",       1, 32'h00208133,  32'h0,      32'h5,        32'hFFFFFFFF, C_ALU|C_NPC|C_REG,           32'h4,        0, 32'h4,     0,            2, 0, 1, 0, 1, 0, 0, 0);
    step("beq_eq",    1, 32'h00208863,  32'h100,    32'h7,        32'h7,        C_ALU|C_BR|C_NPC,            32'h0,        1, 32'h110,   0,            0, 0, 1, 0, 0, 0, 0, 0);
    step("beq_ne",    1, 32'h00208863,  32'h100,    32'h7,        32'h8,        C_ALU|C_BR|C_NPC,            32'hFFFFFFFF, 0, 32'h104,   0,            0, 0, 1, 0, 0, 0, 0, 0);
    step("jalr",      1, 32'h00C280E7,  32'h40,     32'h203,      32'h0,        C_ALU|C_NPC|C_IMM|C_REG,     32'h20F,      0, 32'h20E,   32'h44,       1, 2, 1, 0, 1, 0, 0, 0);
    step("lh",        1, 32'hFFC09183,  32'h300,    32'h1000,     32'h0,        C_ALU|C_NPC|C_REG|C_MEM,     32'hFFC,      0, 32'h304,   0,            3, 1, 1, 1, 1, 0, 1, 1);
    step("ecall",     1, 32'h00000073,  32'h500,    32'h0,        32'h0,        0,                           32'h0,        0, 32'h0,     0,            0, 0, 0, 0, 0, 0, 0, 0);
    step("srai",      1, 32'h4040D093,  32'h10,     32'h80000000, 32'h0,        C_ALU|C_NPC|C_REG,           32'hF8000000, 0, 32'h14,    0,            1, 0, 1, 0, 1, 0, 0, 0);
    step("sub",       1, 32'h402081B3,  32'h20,     32'h3,        32'h5,        C_ALU|C_NPC|C_REG,           32'hFFFFFFFE, 0, 32'h24,    0,            3, 0, 1, 0, 1, 0, 0, 0);
    step("sltu",      1, 32'h0020B233,  32'h24,     32'h1,        32'hFFFFFFFF, C_ALU|C_NPC|C_REG,           32'h1,        0, 32'h28,    0,            4, 0, 1, 0, 1, 0, 0, 0);
    step("lui",       1, 32'h123452B7,  32'h28,     32'h0,        32'h0,        C_NPC|C_IMM|C_REG,           32'h0,        0, 32'h2C,    32'h12345000, 5, 2, 1, 0, 1, 0, 0, 0);
    step("auipc",     1, 32'h00001317,  32'h1000,   32'h0,        32'h0,        C_NPC|C_IMM|C_REG,           32'h0,        0, 32'h1004,  32'h2000,     6, 2, 1, 0, 1, 0, 0, 0);
    step("sw",        1, 32'h0020A423,  32'h30,     32'h100,      32'hDEAD,     C_ALU|C_NPC|C_MEM,           32'h108,      0, 32'h34,    0,            0, 0, 1, 1, 0, 1, 0, 2);
    step("blt_neg",   1, 32'hFE20CCE3,  32'h100,    32'hFFFFFFFF, 32'h1,        C_ALU|C_BR|C_NPC,            32'h1,        1, 32'hF8,    0,            0, 0, 1, 0, 0, 0, 0, 0);
    step("bgeu_nt",   1, 32'h0020F863,  32'h100,    32'h1,        32'h2,        C_ALU|C_BR|C_NPC,            32'h1,        0, 32'h104,   0,            0, 0, 1, 0, 0, 0, 0, 0);
    step("jal",       1, 32'h001000EF,  32'h400,    32'h0,        32'h0,        C_NPC|C_IMM|C_REG,           32'h0,        0, 32'hC00,   32'h404,      1, 2, 1, 0, 1, 0, 0, 0);
    step("mul_ill",   1, 32'h022081B3,  32'h40,     32'h2,        32'h3,        0,                           32'h0,        0, 32'h0,     0,            0, 0, 0, 0, 0, 0, 0, 0);
    step("fence",     1, 32'h0000000F,  32'h50,     32'h0,        32'h0,        C_NPC|C_REG,                 32'h0,        0, 32'h54,    0,            0, 0, 1, 0, 1, 0, 0, 0);
    step("sw_again",  1, 32'h0020A423,  32'h60,     32'h10,       32'h0,        C_ALU|C_MEM,                 32'h18,       0, 32'h0,     0,            0, 0, 1, 1, 0, 1, 0, 2);

    // reset in the middle of a store: NOP must appear without a clock edge
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    push_exp("rst_mid", C_NPC | C_REG, 0, 0, 32'h64, 0, 5'd0, 2'd0, 1, 0, 1, 0, 0, 0);
    check_out();

    // load held high across reset release captures on the releasing edge
    drive(1'b1, 32'h4040D093, 32'h10, 32'h80000000, 32'h0);
    @(posedge clk);
    #1;
    push_exp("rst_load", C_NPC | C_REG, 0, 0, 32'h14, 0, 5'd0, 2'd0, 1, 0, 1, 0, 0, 0);
    check_out();
    @(negedge clk);
    rst_n = 1'b1;
    push_exp("rel_load", C_ALU | C_NPC | C_REG, 32'hF8000000, 0, 32'h14, 0, 5'd1, 2'd0, 1, 0, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    check_out();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
